// File: rtl/watchdog_timer.sv
// rtl/watchdog_timer.sv - watchdog timer with register port and registered timeout interrupt
// Optional prescaler: define WDT_PRESCALE_EN.
module watchdog_timer #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        WTO
);

  typedef enum logic [1:0] {IDLE, COUNT, TIMEOUT} state_e;

  state_e             state_q, state_d;
  logic               wden_q, wden_d;
  logic               wto_q, wto_d;
  logic               restart_q, restart_d;
  logic [CNT_W-1:0]   wtocnt_q, wtocnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic wr_en, en_set, dis, kick, wr_cnt, advance, tick;

  assign wr_en   = reg_we && (reg_addr == 2'd0);
  assign en_set  = wr_en && reg_wdata[0];
  assign dis     = wr_en && !reg_wdata[0];
  assign kick    = reg_we && (reg_addr == 2'd1) && reg_wdata[0];
  assign wr_cnt  = reg_we && (reg_addr == 2'd2);
  // The cycle right after enable/kick holds the counters at zero.
  assign advance = (state_q == COUNT) && !restart_q && !kick && !dis;

`ifdef WDT_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign tick = (pcnt_q == presc_q);

  always_comb begin
    presc_d = presc_q;
    if (reg_we && (reg_addr == 2'd3)) begin
      presc_d = reg_wdata[PRESC_W-1:0];
    end
    pcnt_d = '0;
    if (advance && !tick) begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  localparam logic [PRESC_W-1:0] PRESC_ZERO = '0;

  assign tick = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    wden_d    = wden_q;
    wto_d     = wto_q;
    restart_d = 1'b0;
    cnt_d     = cnt_q;
    wtocnt_d  = wr_cnt ? reg_wdata[CNT_W-1:0] : wtocnt_q;

    if (dis) begin
      state_d = IDLE;
      wden_d  = 1'b0;
      wto_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (en_set) begin
            wden_d    = 1'b1;
            state_d   = COUNT;
            restart_d = 1'b1;
          end
        end
        COUNT: begin
          if (kick) begin
            cnt_d     = '0;
            restart_d = 1'b1;
          end else if (advance && tick) begin
            if (cnt_q >= wtocnt_q) begin
              state_d = TIMEOUT;
              wto_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        TIMEOUT: begin
          if (kick) begin
            state_d   = COUNT;
            wto_d     = 1'b0;
            cnt_d     = '0;
            restart_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          wto_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wden_q    <= 1'b0;
      wto_q     <= 1'b0;
      restart_q <= 1'b0;
      wtocnt_q  <= '1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wden_q    <= wden_d;
      wto_q     <= wto_d;
      restart_q <= restart_d;
      wtocnt_q  <= wtocnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0:    reg_rdata[0] = wden_q;
      2'd1:    reg_rdata[0] = wto_q;
      2'd2:    reg_rdata[CNT_W-1:0] = wtocnt_q;
`ifdef WDT_PRESCALE_EN
      default: reg_rdata[PRESC_W-1:0] = presc_q;
`else
      default: reg_rdata[PRESC_W-1:0] = PRESC_ZERO;
`endif
    endcase
  end

  assign WTO = wto_q;

endmodule

// File: tb/tb_watchdog_timer.sv
// tb/tb_watchdog_timer.sv - randomized self-checking bench for watchdog_timer against a cycle-age model
module tb_watchdog_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_we = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic [31:0] reg_rdata;
  logic        WTO;

  int checks = 0;
  int failures = 0;

  watchdog_timer dut (
    .clk(clk), .rst(rst), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .WTO(WTO)
  );

  always #5 clk = ~clk;

  // Model: time since the last restart (enable/kick) decides everything.
  // Ticks fall at ages 1+k*(P+1), k>=1; timeout on the tick that finds
  // the number of earlier ticks >= WTOCNT.
  bit          m_en = 1'b0;
  bit          m_wto = 1'b0;
  longint      m_age = 0;
  logic [31:0] m_tocnt = 32'hFFFF_FFFF;
  logic [7:0]  m_presc = 8'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_en = 1'b0; m_wto = 1'b0; m_age = 0;
      m_tocnt = 32'hFFFF_FFFF; m_presc = 8'd0;
    end else begin
      bit w_en, w_kick;
      w_en   = reg_we && reg_addr == 2'd0;
      w_kick = reg_we && reg_addr == 2'd1 && reg_wdata[0];
      if (w_en && !reg_wdata[0]) begin
        m_en = 1'b0; m_wto = 1'b0;
      end else if (w_en && !m_en) begin
        m_en = 1'b1; m_age = 0;
      end else if (w_kick && m_en) begin
        m_wto = 1'b0; m_age = 0;
      end else if (m_en && !m_wto) begin
        longint p;
        p = longint'(m_presc) + 1;
        m_age++;
        if (m_age >= 2 && (m_age - 1) % p == 0 && ((m_age - 1) / p - 1) >= longint'(m_tocnt))
          m_wto = 1'b1;
      end
      if (reg_we && reg_addr == 2'd2) m_tocnt = reg_wdata;
`ifdef WDT_PRESCALE_EN
      if (reg_we && reg_addr == 2'd3) m_presc = reg_wdata[7:0];
`endif
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {31'd0, m_en};
      2'd1:    return {31'd0, m_wto};
      2'd2:    return m_tocnt;
      default: return {24'd0, m_presc};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("wto_vs_model", {63'd0, WTO}, {63'd0, m_wto});
    chk("rdata_vs_model", {32'd0, reg_rdata}, {32'd0, exp_rd(reg_addr)});
  end

  task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    reg_we = we; reg_addr = a; reg_wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 2'd1, 32'd0);
      if (WTO) highs++;
    end
  endtask

  task automatic wait_wto(input int max_n, output int k);
    k = max_n + 1;
    for (int i = 1; i <= max_n; i++) begin
      step(1'b0, 2'd1, 32'd0);
      if (WTO) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k, highs;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wto", {63'd0, WTO}, 64'd0);
    reg_addr = 2'd0; #1;
    chk("reset_wden", {32'd0, reg_rdata}, 64'd0);
    reg_addr = 2'd2; #1;
    chk("reset_wtocnt", {32'd0, reg_rdata}, 64'hFFFF_FFFF);
    @(negedge clk); #1; rst = 1'b1;

    idle_count_high(100, highs);
    chk("no_wto_after_reset", highs, 0);

    step(1'b1, 2'd2, 32'd3);
    step(1'b1, 2'd3, 32'd0);
    step(1'b1, 2'd0, 32'd1);
    wait_wto(20, k);
    chk("basic_rise_edges", k, 5);
    idle_count_high(50, highs);
    chk("basic_stays_high", highs, 50);

    step(1'b1, 2'd1, 32'd1);
    chk("kick_clears_wto", {63'd0, WTO}, 64'd0);
    wait_wto(20, k);
    chk("kick_rearm_edges", k, 5);

    step(1'b1, 2'd0, 32'd0);
    chk("disable_clears_wto", {63'd0, WTO}, 64'd0);
    idle_count_high(20, highs);
    chk("disable_stays_low", highs, 0);

    step(1'b1, 2'd2, 32'd5);
    step(1'b1, 2'd0, 32'd1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      idle_count_high(3, k);
      highs += k;
      step(1'b1, 2'd1, 32'd1);
      if (WTO) highs++;
    end
    chk("periodic_kick_no_wto", highs, 0);
    wait_wto(20, k);
    chk("after_last_kick_edges", k, 7);

    step(1'b1, 2'd0, 32'd0);
    step(1'b1, 2'd2, 32'd0);
    step(1'b1, 2'd0, 32'd1);
    wait_wto(10, k);
    chk("wtocnt0_edges", k, 2);

    step(1'b1, 2'd0, 32'd0);
    step(1'b1, 2'd2, 32'd3);
    step(1'b1, 2'd0, 32'd1);
    idle_count_high(4, highs);
    step(1'b1, 2'd1, 32'd1);
    chk("kick_on_compare_no_wto", {63'd0, WTO}, 64'd0);
    wait_wto(20, k);
    chk("kick_on_compare_rearm", k, 5);

    step(1'b1, 2'd0, 32'd0);
    step(1'b1, 2'd1, 32'd1);
    idle_count_high(10, highs);
    chk("kick_in_idle_no_wto", highs, 0);
    reg_addr = 2'd0; #1;
    chk("idle_wden_reads0", {32'd0, reg_rdata}, 64'd0);

    step(1'b1, 2'd2, 32'd20);
    step(1'b1, 2'd0, 32'd1);
    idle_count_high(11, highs);
    step(1'b1, 2'd2, 32'd2);
    wait_wto(5, k);
    chk("reprogram_below_count", k, 1);

    @(negedge clk); #3; rst = 1'b0; #1;
    chk("async_reset_wto", {63'd0, WTO}, 64'd0);
    @(negedge clk); #1; rst = 1'b1;

`ifdef WDT_PRESCALE_EN
    step(1'b1, 2'd3, 32'd3);
    step(1'b1, 2'd2, 32'd2);
    step(1'b1, 2'd0, 32'd1);
    wait_wto(30, k);
    chk("presc_rise_edges", k, 13);
    step(1'b1, 2'd1, 32'd1);
    idle_count_high(5, highs);
    @(negedge clk); #3; rst = 1'b0; #1;
    chk("presc_reset_wto", {63'd0, WTO}, 64'd0);
    reg_addr = 2'd3; #1;
    chk("presc_reset_reads0", {32'd0, reg_rdata}, 64'd0);
    @(negedge clk); #1; rst = 1'b1;
`endif

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      step(1'b0, 2'($urandom_range(0, 3)), $urandom);
      else if (r < 80) step(1'b1, 2'd1, {$urandom_range(0, 1) ? 31'd0 : 31'd5, ($urandom_range(0, 3) != 0)});
      else if (r < 85) step(1'b1, 2'd0, 32'd1);
      else if (r < 88) step(1'b1, 2'd0, 32'd0);
      else if (r < 95) step(1'b1, 2'd2, 32'($urandom_range(0, 12)));
      else if (!m_en)  step(1'b1, 2'd3, 32'($urandom_range(0, 3)));
      else             step(1'b0, 2'd3, 32'd0);
    end
    step(1'b0, 2'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watchdog_timer.md
# watchdog_timer

Watchdog timer that drives the timer-interrupt request consumed by the CPU interrupt controller: its `WTO` output connects directly to the controller's `WDT_interrupt` input and is qualified there by `MTIE`. Software configures it through a small word-addressed register port. Software enables it, sets a timeout and periodically kicks it. If the count reaches the timeout without a kick, `WTO` asserts and stays high until software kicks or disables the watchdog.

## Interface
- `CNT_W`, default 32: width of the timeout counter and the `WTOCNT` register.
- `PRESC_W`, default 8: width of the prescaler register and counter. Unused without the macro.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low. Asserting it (0) clears all state immediately; release is synchronised externally.
- `reg_we` in 1: register write strobe, sampled on `clk`.
- `reg_addr` in 2: register select. 0 = WDEN, 1 = WDLIVE/STATUS, 2 = WTOCNT, 3 = PRESC.
- `reg_wdata` in 32: write data. Only the low bits relevant to each register are used.
- `reg_rdata` out 32: combinational read of the register selected by `reg_addr`.
- `WTO` out 1: registered timeout interrupt level, to the interrupt controller.

## Operation
- **Registers**
  - WDEN: bit0 enables the watchdog. Reset 0.
  - WDLIVE: a write with `wdata[0]=1` is a kick. Nothing is stored. A read returns `{31'b0, WTO}`.
  - WTOCNT: timeout value, `[CNT_W-1:0]`. Reset all ones. Reads return the value zero-extended.
  - PRESC: prescale value, `[PRESC_W-1:0]`. Reset 0.
- **FSM states: IDLE, COUNT, TIMEOUT.** Reset state is IDLE with counter 0, prescale counter 0 and `WTO`=0.
- **IDLE**
  - Counter and prescale counter are held at 0.
  - A write of WDEN=1 moves to COUNT.
- **COUNT**
  - A tick occurs when the prescale counter equals PRESC; the prescale counter then wraps to 0. Otherwise the prescale counter increments.
  - On a tick: if counter >= WTOCNT, go to TIMEOUT and set `WTO`=1. Otherwise increment the counter.
  - The comparison is >=, so reprogramming WTOCNT below the current count causes a timeout on the next tick. There is no wrap-around.
- **TIMEOUT**
  - Counters are frozen and `WTO`=1.
  - A kick clears `WTO`, zeroes both counters and returns to COUNT.
- **Kick in COUNT:** zeroes both counters.
- **WDEN=0 from any state:** goes to IDLE, clears `WTO` and zeroes both counters.
- **Priority, highest first:** reset, then disable, then kick, then tick. A kick in the same cycle as a tick suppresses that tick's comparison and increment.
- **WTOCNT or PRESC writes** take effect on the next cycle's comparison. They do not reset the counters.
- **Writing WDEN=1 while already enabled** has no effect and does not restart the count.

## Timing
- All outputs except `reg_rdata` are registered. `reg_rdata` is combinational from `reg_addr` and the register state.
- If the enable write is sampled at edge N (counter 0 at N+1), `WTO` rises at edge N + (WTOCNT+1)·(PRESC+1) + 1. Without the prescaler this is N + WTOCNT + 2.
- A kick or disable sampled at edge K drops `WTO` at edge K, visible in the cycle after K.
- A kick sampled at edge K restarts timing as if the enable had been sampled at K.
- Asserting `rst` asynchronously forces `WTO`=0, state IDLE and all registers to their reset values mid-operation, with no clock edge required.

## Configuration
- **`WDT_PRESCALE_EN` defined:** the PRESC register and prescale counter exist and ticks occur every PRESC+1 cycles.
- **`WDT_PRESCALE_EN` not defined:**
  - The prescaler logic is removed and every COUNT cycle is a tick, equivalent to PRESC=0.
  - Address 3 reads 0 and writes to it are ignored.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles → `WTO`=0, WDEN reads 0, WTOCNT reads 0xFFFF_FFFF, and `WTO` stays 0 for 100 cycles after release.
- **Basic timeout:** WTOCNT=3, PRESC=0, enable sampled at edge 10 → `WTO` rises at edge 15 and stays high for 50 cycles.
- **Kick:** WTOCNT=5, enable, then kick every 4 cycles for 40 cycles → `WTO` never asserts. Stop kicking → `WTO` rises 7 edges after the last kick.
- **Clear and boundary:**
  - While `WTO`=1, a kick drops `WTO` next cycle and it re-asserts WTOCNT+2 edges later.
  - While `WTO`=1, a disable drops `WTO` and it stays low.
  - With WTOCNT=0, `WTO` rises 2 edges after the enable.
- **Simultaneous events and reprogramming:**
  - Kick in the same cycle the comparison would succeed → no timeout.
  - Disable and kick in the same cycle → IDLE.
  - Write WTOCNT=2 while the counter is 10 → `WTO` rises next tick.
- **Prescaler (macro defined):** PRESC=3, WTOCNT=2, enable at edge 0 → `WTO` rises at edge 13. Assert `rst` mid-count → `WTO` is 0 immediately and PRESC reads 0.
